// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_t     : access FSM encoding (IDLE/REQ/WAIT/DONE), also exported on the debug port
//   TMO_CYC_DEF : default bus timeout in cycles spent in REQ+WAIT
//   TMO_CNT_W   : width of the timeout counter (limits TMO_CYC to 1..255)
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int TMO_CYC_DEF = 255;
    localparam int TMO_CNT_W   = 8;

endpackage

// File: rtl/mem_tmo_cnt.sv
// Bus timeout counter for the MEM stage.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   i_clr      : zero the count (asserted on the cycle that enters REQ)
//   i_en       : count this cycle (asserted while in REQ or WAIT)
//   o_expire   : this is the TMO_CYC-th enabled cycle since the last clear
module mem_tmo_cnt
    import mem_stage_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TMO_CYC - 1);

    logic [TMO_CNT_W-1:0] r_cnt;

    // Saturates so a completion on the expiry cycle cannot wrap the count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count equals k-1 during the k-th enabled cycle after a clear.
    assign o_expire = i_en && (r_cnt >= LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline. Takes the EX/MEM register outputs, performs
// loads/stores on a variable-latency data memory (req/gnt/rvalid), stalls the pipeline
// while an access is outstanding and registers the MEM/WB values.
// Ports:
//   Clk, Rst_n                       : clock, asynchronous active-low reset
//   MemR_EX, MemW_EX, Mem2R_EX,
//   RegW_EX, aluDataOut_EX,
//   MEM_rfDataOut2, EX_rfWeSel       : EX/MEM register contents
//   dm_req/dm_we/dm_addr/dm_wdata    : memory request, held stable until dm_gnt
//   dm_gnt, dm_rvalid, dm_rdata      : memory grant and read return
//   MemStall                         : combinational freeze of PC .. EX/MEM
//   RegW_MEM, Mem2R_MEM, aluDataOut_MEM,
//   MemDataOut_MEM, MEM_rfWeSel      : MEM/WB register
//   MemErr                           : one-cycle error pulse (timeout or misalign trap)
//   dbg_state                        : current FSM state (state_t encoding)
// Build option: define MEM_MISALIGN_TRAP_EN to trap accesses with addr[1:0] != 0;
// otherwise the low address bits are dropped and the access proceeds.
// Memory handshake: dm_req stays high with dm_we/dm_addr/dm_wdata unchanged until the
// cycle dm_gnt is seen high; dm_rvalid is only honoured in WAIT (cycle after gnt or later).
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MemR_EX,
    input  logic              MemW_EX,
    input  logic              Mem2R_EX,
    input  logic              RegW_EX,
    input  logic [DATA_W-1:0] aluDataOut_EX,
    input  logic [DATA_W-1:0] MEM_rfDataOut2,
    input  logic [4:0]        EX_rfWeSel,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              MemStall,
    output logic              RegW_MEM,
    output logic              Mem2R_MEM,
    output logic [DATA_W-1:0] aluDataOut_MEM,
    output logic [DATA_W-1:0] MemDataOut_MEM,
    output logic [4:0]        MEM_rfWeSel,
    output logic              MemErr,
    output logic [1:0]        dbg_state
);

    state_t              r_state;
    logic                r_req, r_we, r_tmo, r_err;
    logic [DATA_W-1:0]   r_addr, r_wdata, r_rdata;
    logic                r_regw, r_mem2r;
    logic [DATA_W-1:0]   r_alu, r_mdata;
    logic [4:0]          r_rd;

    logic                w_mem_op, w_trap, w_expire, w_tmo_clr, w_tmo_en;
    logic [DATA_W-1:0]   w_addr;

    assign w_mem_op = MemR_EX | MemW_EX;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_mem_op && (aluDataOut_EX[1:0] != 2'b00);
    assign w_addr = aluDataOut_EX;
`else
    assign w_trap = 1'b0;
    assign w_addr = {aluDataOut_EX[DATA_W-1:2], 2'b00};
`endif

    assign w_tmo_clr = (r_state == ST_IDLE) && w_mem_op && !w_trap;
    assign w_tmo_en  = (r_state == ST_REQ) || (r_state == ST_WAIT);

    mem_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_regw  <= 1'b0;
            r_mem2r <= 1'b0;
            r_alu   <= '0;
            r_mdata <= '0;
            r_rd    <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trap) begin
                        r_err   <= 1'b1;
                        r_regw  <= 1'b0;
                        r_mem2r <= 1'b0;
                    end else if (w_mem_op) begin
                        // Store wins when both MemR and MemW are set.
                        r_we    <= MemW_EX;
                        r_addr  <= w_addr;
                        r_wdata <= MEM_rfDataOut2;
                        r_req   <= 1'b1;
                        r_tmo   <= 1'b0;
                        r_regw  <= 1'b0;
                        r_mem2r <= 1'b0;
                        r_state <= ST_REQ;
                    end else begin
                        r_regw  <= RegW_EX;
                        r_mem2r <= Mem2R_EX;
                        r_alu   <= aluDataOut_EX;
                        r_rd    <= EX_rfWeSel;
                    end
                end
                ST_REQ: begin
                    r_regw  <= 1'b0;
                    r_mem2r <= 1'b0;
                    if (dm_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? ST_DONE : ST_WAIT;
                    end else if (w_expire) begin
                        r_req   <= 1'b0;
                        r_tmo   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    r_regw  <= 1'b0;
                    r_mem2r <= 1'b0;
                    if (dm_rvalid) begin
                        r_rdata <= dm_rdata;
                        r_state <= ST_DONE;
                    end else if (w_expire) begin
                        r_tmo   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EX/MEM still holds the memory instruction; it advances at this edge.
                    r_regw  <= RegW_EX && !r_tmo;
                    r_mem2r <= Mem2R_EX;
                    r_alu   <= aluDataOut_EX;
                    r_rd    <= EX_rfWeSel;
                    if (r_tmo) begin
                        r_mdata <= '0;
                    end else if (!r_we) begin
                        r_mdata <= r_rdata;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so the stall releases immediately when reset is asserted.
    assign MemStall = Rst_n && (((r_state == ST_IDLE) && w_mem_op && !w_trap) ||
                                (r_state == ST_REQ) || (r_state == ST_WAIT));

    assign dm_req         = r_req;
    assign dm_we          = r_we;
    assign dm_addr        = r_addr;
    assign dm_wdata       = r_wdata;
    assign RegW_MEM       = r_regw;
    assign Mem2R_MEM      = r_mem2r;
    assign aluDataOut_MEM = r_alu;
    assign MemDataOut_MEM = r_mdata;
    assign MEM_rfWeSel    = r_rd;
    assign MemErr         = r_err;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MemR_EX, MemW_EX, Mem2R_EX, RegW_EX;
    logic [31:0] aluDataOut_EX, MEM_rfDataOut2;
    logic [4:0]  EX_rfWeSel;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = 32'h0;
    logic        MemStall, RegW_MEM, Mem2R_MEM, MemErr;
    logic [31:0] aluDataOut_MEM, MemDataOut_MEM;
    logic [4:0]  MEM_rfWeSel;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // results of the memory responder
    int          st, rq;
    logic [31:0] la, lw;
    logic        lwe;
    bit          uns, expd;

    mem_access_stage #(.DATA_W(32), .TMO_CYC(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .MemR_EX(MemR_EX), .MemW_EX(MemW_EX), .Mem2R_EX(Mem2R_EX), .RegW_EX(RegW_EX),
        .aluDataOut_EX(aluDataOut_EX), .MEM_rfDataOut2(MEM_rfDataOut2), .EX_rfWeSel(EX_rfWeSel),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .MemStall(MemStall), .RegW_MEM(RegW_MEM), .Mem2R_MEM(Mem2R_MEM),
        .aluDataOut_MEM(aluDataOut_MEM), .MemDataOut_MEM(MemDataOut_MEM),
        .MEM_rfWeSel(MEM_rfWeSel), .MemErr(MemErr), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic set_op(input logic r, input logic w, input logic m2r, input logic rw,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        MemR_EX = r; MemW_EX = w; Mem2R_EX = m2r; RegW_EX = rw;
        aluDataOut_EX = a; MEM_rfDataOut2 = d; EX_rfWeSel = rd;
    endtask

    task automatic set_nop();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Called at a negedge right after an access was applied. Answers dm_req with gnt after
    // gnt_dly waiting cycles, then rvalid on the following cycle (if rv_en). Counts stall
    // cycles and returns at the first non-stalled negedge (or after a 40-cycle budget).
    task automatic run_access(input int gnt_dly, input bit rv_en, input logic [31:0] rv_data,
                              output int stalls, output int req_n,
                              output logic [31:0] l_addr, output logic [31:0] l_wdata,
                              output logic l_we, output bit unstable, output bit expired);
        bit granted, seen;
        stalls = 0; req_n = 0; granted = 0; seen = 0; unstable = 0; expired = 1;
        l_addr = 32'h0; l_wdata = 32'h0; l_we = 1'b0;
        #1;
        for (int c = 0; c < 40; c++) begin
            dm_gnt = 1'b0; dm_rvalid = 1'b0;
            if (MemStall !== 1'b1) begin
                expired = 0;
                break;
            end
            stalls++;
            if (granted) begin
                if (rv_en) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = rv_data;
                end
            end else if (dm_req === 1'b1) begin
                if (!seen) begin
                    seen = 1; l_addr = dm_addr; l_wdata = dm_wdata; l_we = dm_we;
                end else if (dm_addr !== l_addr || dm_wdata !== l_wdata || dm_we !== l_we) begin
                    unstable = 1;
                end
                if (req_n == gnt_dly) begin
                    dm_gnt = 1'b1;
                    granted = 1;
                end
                req_n++;
            end
            @(negedge Clk);
        end
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        Rst_n = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 32'h66, 5'd3);
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if ({dm_req, dm_we, MemStall, RegW_MEM, Mem2R_MEM, MemErr, dbg_state} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {dm_req, dm_we, MemStall, RegW_MEM, Mem2R_MEM, MemErr, dbg_state});
            errors++;
        end
        @(negedge Clk);
        checks++;
        if ({dm_addr, dm_wdata, aluDataOut_MEM, MemDataOut_MEM, MEM_rfWeSel} !== 133'h0) begin
            $display("FAIL reset_data: got %h/%h/%h/%h/%h expected all zero",
                     dm_addr, dm_wdata, aluDataOut_MEM, MemDataOut_MEM, MEM_rfWeSel);
            errors++;
        end
        set_nop();
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if ({MemStall, RegW_MEM, dm_req} !== 3'b000) begin
            $display("FAIL reset_release: got %b expected 000", {MemStall, RegW_MEM, dm_req});
            errors++;
        end
    endtask

    task automatic test_alu();
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);
        #1;
        checks++;
        if (MemStall !== 1'b0) begin
            $display("FAIL alu_stall: got %b expected 0", MemStall);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if ({RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM} !== {1'b1, 1'b0, 5'd5, 32'h10}) begin
            $display("FAIL alu_memwb: got %b %b %0d %h expected 1 0 5 00000010",
                     RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM);
            errors++;
        end
        set_nop();
    endtask

    task automatic test_load();
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
        run_access(0, 1'b1, 32'hCAFEF00D, st, rq, la, lw, lwe, uns, expd);
        checks++;
        if (st !== 3 || expd) begin
            $display("FAIL load_stall: got %0d cycles (budget expired %0d) expected 3", st, expd);
            errors++;
        end
        checks++;
        if ({la, lwe} !== {32'h100, 1'b0}) begin
            $display("FAIL load_req: got addr %h we %b expected 00000100 0", la, lwe);
            errors++;
        end
        checks++;
        if (RegW_MEM !== 1'b0) begin
            $display("FAIL load_bubble: got RegW_MEM %b expected 0", RegW_MEM);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if (MemDataOut_MEM !== 32'hCAFEF00D) begin
            $display("FAIL load_data: got %h expected cafef00d", MemDataOut_MEM);
            errors++;
        end
        checks++;
        if ({RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM} !== {1'b1, 1'b1, 5'd7, 32'h100}) begin
            $display("FAIL load_memwb: got %b %b %0d %h expected 1 1 7 00000100",
                     RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM);
            errors++;
        end
        set_nop();
    endtask

    task automatic test_store_delayed_gnt();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 5'd0);
        run_access(4, 1'b0, 32'h0, st, rq, la, lw, lwe, uns, expd);
        checks++;
        if (st !== 6 || rq !== 5 || expd) begin
            $display("FAIL store_stall: got %0d stall %0d req cycles expected 6 5", st, rq);
            errors++;
        end
        checks++;
        if ({la, lw, lwe, uns} !== {32'h200, 32'h12345678, 1'b1, 1'b0}) begin
            $display("FAIL store_req: got addr %h data %h we %b unstable %b expected 00000200 12345678 1 0",
                     la, lw, lwe, uns);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if (MemDataOut_MEM !== 32'hCAFEF00D || RegW_MEM !== 1'b0) begin
            $display("FAIL store_hold: got data %h regw %b expected cafef00d 0", MemDataOut_MEM, RegW_MEM);
            errors++;
        end
        set_nop();
    endtask

    task automatic test_read_write_both();
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'hA5A5A5A5, 5'd0);
        run_access(0, 1'b1, 32'h0BAD0BAD, st, rq, la, lw, lwe, uns, expd);
        checks++;
        if (st !== 2 || lwe !== 1'b1 || lw !== 32'hA5A5A5A5) begin
            $display("FAIL both_as_store: got %0d stalls we %b data %h expected 2 1 a5a5a5a5", st, lwe, lw);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if (MemDataOut_MEM !== 32'hCAFEF00D) begin
            $display("FAIL both_hold: got %h expected cafef00d", MemDataOut_MEM);
            errors++;
        end
        set_nop();
    endtask

    task automatic test_timeout();
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd9);
        run_access(0, 1'b0, 32'h0, st, rq, la, lw, lwe, uns, expd);
        checks++;
        if (st !== 9 || expd) begin
            $display("FAIL tmo_stall: got %0d cycles expected 9", st);
            errors++;
        end
        checks++;
        if (MemErr !== 1'b1) begin
            $display("FAIL tmo_err: got %b expected 1", MemErr);
            errors++;
        end
        // late read data must be ignored
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hDEADBEEF;
        @(negedge Clk);
        dm_rvalid = 1'b0;
        checks++;
        if ({MemErr, RegW_MEM, MemDataOut_MEM} !== {1'b0, 1'b0, 32'h0}) begin
            $display("FAIL tmo_memwb: got err %b regw %b data %h expected 0 0 00000000",
                     MemErr, RegW_MEM, MemDataOut_MEM);
            errors++;
        end
        set_nop();
        @(negedge Clk);
        checks++;
        if ({MemStall, MemErr, dbg_state} !== 4'b0000) begin
            $display("FAIL tmo_resume: got %b expected 0000", {MemStall, MemErr, dbg_state});
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 5'd1);
        @(negedge Clk);
        checks++;
        if ({RegW_MEM, MEM_rfWeSel, aluDataOut_MEM} !== {1'b1, 5'd1, 32'h20}) begin
            $display("FAIL b2b_first: got %b %0d %h expected 1 1 00000020", RegW_MEM, MEM_rfWeSel, aluDataOut_MEM);
            errors++;
        end
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd2);
        @(negedge Clk);
        checks++;
        if ({RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM} !== {1'b0, 1'b1, 5'd2, 32'h30}) begin
            $display("FAIL b2b_second: got %b %b %0d %h expected 0 1 2 00000030",
                     RegW_MEM, Mem2R_MEM, MEM_rfWeSel, aluDataOut_MEM);
            errors++;
        end
        set_nop();
    endtask

    task automatic test_misalign();
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd3);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        checks++;
        if ({MemStall, dm_req} !== 2'b00) begin
            $display("FAIL misalign_nostall: got %b expected 00", {MemStall, dm_req});
            errors++;
        end
        @(negedge Clk);
        checks++;
        if ({MemErr, RegW_MEM, dm_req} !== 3'b100) begin
            $display("FAIL misalign_trap: got %b expected 100", {MemErr, RegW_MEM, dm_req});
            errors++;
        end
        set_nop();
        @(negedge Clk);
        checks++;
        if (MemErr !== 1'b0) begin
            $display("FAIL misalign_pulse: got %b expected 0", MemErr);
            errors++;
        end
`else
        run_access(0, 1'b1, 32'h11223344, st, rq, la, lw, lwe, uns, expd);
        checks++;
        if (la !== 32'h100 || st !== 3) begin
            $display("FAIL misalign_addr: got addr %h stalls %0d expected 00000100 3", la, st);
            errors++;
        end
        @(negedge Clk);
        checks++;
        if ({MemDataOut_MEM, aluDataOut_MEM, MemErr} !== {32'h11223344, 32'h102, 1'b0}) begin
            $display("FAIL misalign_data: got %h %h err %b expected 11223344 00000102 0",
                     MemDataOut_MEM, aluDataOut_MEM, MemErr);
            errors++;
        end
        set_nop();
`endif
    endtask

    task automatic test_reset_mid_access();
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd8);
        run_access(0, 1'b1, 32'h0BADF00D, st, rq, la, lw, lwe, uns, expd);
        @(negedge Clk);
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 5'd4);
        @(negedge Clk);
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd6);
        @(negedge Clk);
        dm_gnt = (dm_req === 1'b1);
        @(negedge Clk);
        dm_gnt = 1'b0;
        checks++;
        if ({MemStall, dbg_state, aluDataOut_MEM, MemDataOut_MEM} !== {1'b1, 2'd2, 32'h44, 32'h0BADF00D}) begin
            $display("FAIL rst_pre_wait: got stall %b state %0d alu %h data %h expected 1 2 00000044 0badf00d",
                     MemStall, dbg_state, aluDataOut_MEM, MemDataOut_MEM);
            errors++;
        end
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({dm_req, MemStall, RegW_MEM, Mem2R_MEM, MemErr, MEM_rfWeSel} !== 10'h0 ||
            {aluDataOut_MEM, MemDataOut_MEM, dm_addr} !== 96'h0) begin
            $display("FAIL rst_in_wait: got %b %h %h %h expected all zero",
                     {dm_req, MemStall, RegW_MEM, Mem2R_MEM, MemErr, MEM_rfWeSel},
                     aluDataOut_MEM, MemDataOut_MEM, dm_addr);
            errors++;
        end
        @(negedge Clk);
        set_nop();
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if ({dbg_state, MemStall} !== 3'b000) begin
            $display("FAIL rst_idle: got %b expected 000", {dbg_state, MemStall});
            errors++;
        end
        // asynchronous drop of a pending request
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 32'h77, 5'd0);
        @(negedge Clk);
        checks++;
        if (dm_req !== 1'b1) begin
            $display("FAIL rst_pre_req: got %b expected 1", dm_req);
            errors++;
        end
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({dm_req, dm_we, MemStall} !== 3'b000) begin
            $display("FAIL rst_in_req: got %b expected 000", {dm_req, dm_we, MemStall});
            errors++;
        end
        @(negedge Clk);
        set_nop();
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_delayed_gnt();
        test_read_write_both();
        test_timeout();
        test_back_to_back();
        test_misalign();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
